// File: rtl/usbf_cdc_chan_arb.sv
// Source-side round-robin arbiter and sequencer for one toggle-handshake CDC channel.
// Captures the winner's data/ID, flips ch_tgl, then waits for the matching ack toggle.
module usbf_cdc_chan_arb #(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int IDW   = 2,
  parameter int TMO_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*DW-1:0]  req_data,
  output logic [NREQ-1:0]     gnt,
  output logic                ch_tgl,
  output logic [DW-1:0]       ch_data,
  output logic [IDW-1:0]      ch_id,
  input  logic                ch_ack_tgl,
  output logic                busy,
  output logic                tmo_err,
  input  logic                tmo_clr
);

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_WAIT_ACK = 1'b1;
  localparam int         CW         = IDW + 1;

  logic [0:0]       state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             tgl_q, tgl_d;
  logic [DW-1:0]    data_q, data_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             tmo_q, tmo_d;

  logic             free_s;
  logic             found_s;
  logic [IDW-1:0]   win_s;
  logic [CW-1:0]    idx_s;
  logic [CW-1:0]    nxt_s;
  logic             tmo_set_s;

  assign free_s = (ch_ack_tgl == tgl_q);

  // Search ptr, ptr+1, ... with an explicit wrap so non-power-of-2 NREQ works.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    idx_s   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = {1'b0, ptr_q} + CW'(k);
      if (idx_s >= CW'(NREQ)) begin
        idx_s = idx_s - CW'(NREQ);
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && req[idx_s[IDW-1:0]]) begin
        found_s = 1'b1;
        win_s   = idx_s[IDW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  assign nxt_s     = {1'b0, win_s} + CW'(1);
  assign tmo_set_s = (state_q == S_WAIT_ACK) && !free_s && (cnt_q == {TMO_W{1'b1}});

  // Next-state logic for the grant/handshake sequencer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    tgl_d   = tgl_q;
    data_d  = data_q;
    id_d    = id_q;
    case (state_q)
      S_IDLE: begin
        if (free_s && found_s) begin
          data_d  = req_data[win_s*DW +: DW];
          id_d    = win_s;
          tgl_d   = ~tgl_q;
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
          cnt_d   = '0;
          ptr_d   = (nxt_s == CW'(NREQ)) ? '0 : nxt_s[IDW-1:0];
          state_d = S_WAIT_ACK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_ACK: begin
        if (free_s) begin
          state_d = S_IDLE;
        end else if (cnt_q != {TMO_W{1'b1}}) begin
          cnt_d = cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Set beats clear so a held tmo_clr cannot hide a still-stalled handshake.
    if (tmo_set_s) begin
      tmo_d = 1'b1;
    end else if (tmo_clr) begin
      tmo_d = 1'b0;
    end else begin
      tmo_d = tmo_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      tgl_q   <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      tgl_q   <= tgl_d;
      data_q  <= data_d;
      id_q    <= id_d;
      tmo_q   <= tmo_d;
    end
  end

  assign gnt     = gnt_q;
  assign ch_tgl  = tgl_q;
  assign ch_data = data_q;
  assign ch_id   = id_q;
  assign busy    = (state_q == S_WAIT_ACK);
  assign tmo_err = tmo_q;

endmodule
